// File: rtl/timekeeper_if.sv
// Control and time-display bundle between a timekeeper and its host.
// The host drives run and the adjust controls; the timekeeper drives time and strobes.
interface timekeeper_if;
    logic       run;
    logic [1:0] select;
    logic       increment;
    logic       decrement;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       sec_pulse;
    logic       min_pulse;
    logic       day_pulse;

    modport master (
        output run, select, increment, decrement,
        input  sec, min, hour, sec_pulse, min_pulse, day_pulse
    );

    modport slave (
        input  run, select, increment, decrement,
        output sec, min, hour, sec_pulse, min_pulse, day_pulse
    );
endinterface

// File: rtl/timekeeper.sv
// Hours/minutes/seconds clock driven by a clk prescaler.
// Supports manual per-field adjustment via edge-detected inc/dec inputs.
module timekeeper #(
    parameter int unsigned TICKS_PER_SEC = 32'd50000000
) (
    input logic         clk,
    input logic         reset,
    timekeeper_if.slave bus
);
    localparam logic [31:0] LAST = 32'(TICKS_PER_SEC - 1);

    logic [31:0] presc_q, presc_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic        sp_q, sp_d;
    logic        mp_q, mp_d;
    logic        dp_q, dp_d;
    logic        inc_prev_q, dec_prev_q;
    logic        inc_edge, dec_edge, adj;

    function automatic logic [5:0] wrap60(logic [5:0] v, logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] wrap24(logic [4:0] v, logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    always_comb begin
        inc_edge = bus.increment & ~inc_prev_q;
        dec_edge = bus.decrement & ~dec_prev_q;
        // Simultaneous inc/dec edges cancel and leave counting untouched
        adj      = (bus.select != 2'b00) & (inc_edge ^ dec_edge);
        presc_d  = presc_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        sp_d     = 1'b0;
        mp_d     = 1'b0;
        dp_d     = 1'b0;
        if (adj) begin
            presc_d = '0;
            case (bus.select)
                2'b01:   sec_d  = wrap60(sec_q, inc_edge);
                2'b10:   min_d  = wrap60(min_q, inc_edge);
                2'b11:   hour_d = wrap24(hour_q, inc_edge);
                default: ;
            endcase
        end else if (bus.run) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                sp_d    = 1'b1;
                sec_d   = wrap60(sec_q, 1'b1);
                if (sec_q == 6'd59) begin
                    mp_d  = 1'b1;
                    min_d = wrap60(min_q, 1'b1);
                    if (min_q == 6'd59) begin
                        hour_d = wrap24(hour_q, 1'b1);
                        dp_d   = (hour_q == 5'd23);
                    end
                end
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sp_q       <= 1'b0;
            mp_q       <= 1'b0;
            dp_q       <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sp_q       <= sp_d;
            mp_q       <= mp_d;
            dp_q       <= dp_d;
            inc_prev_q <= bus.increment;
            dec_prev_q <= bus.decrement;
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.sec_pulse = sp_q;
    assign bus.min_pulse = mp_q;
    assign bus.day_pulse = dp_q;
endmodule

// File: tb/tb_timekeeper.sv
// Directed bench for timekeeper with a cycle model feeding a scoreboard queue.
// TICKS_PER_SEC is 4 so a second lasts four clocks.
module tb_timekeeper;
    logic clk = 1'b0;
    logic reset;
    timekeeper_if bus();

    timekeeper #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic [2:0] p;
    } exp_t;

    exp_t sbq[$];
    int   sp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_presc, m_s, m_m, m_h;
    bit   m_ip, m_dp;
    int   cyc_no = 0;
    int   np_all = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        exp_t e;
        bit   ie, de;
        int   d;
        logic [2:0] p;
        repeat (n) begin
            if (reset) begin
                m_presc = 0; m_s = 0; m_m = 0; m_h = 0;
                m_ip = 0; m_dp = 0;
                e = '0;
            end else begin
                ie = bus.increment && !m_ip;
                de = bus.decrement && !m_dp;
                m_ip = bus.increment;
                m_dp = bus.decrement;
                p = 3'b000;
                if (bus.select != 2'b00 && ie != de) begin
                    d = ie ? 1 : -1;
                    case (bus.select)
                        2'b01:   m_s = (m_s + d + 60) % 60;
                        2'b10:   m_m = (m_m + d + 60) % 60;
                        default: m_h = (m_h + d + 24) % 24;
                    endcase
                    m_presc = 0;
                end else if (bus.run) begin
                    if (m_presc == 3) begin
                        m_presc = 0;
                        m_s++;
                        p[0] = 1'b1;
                        if (m_s == 60) begin
                            m_s = 0;
                            m_m++;
                            p[1] = 1'b1;
                            if (m_m == 60) begin
                                m_m = 0;
                                m_h++;
                                if (m_h == 24) begin
                                    m_h = 0;
                                    p[2] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        m_presc++;
                    end
                end
                e.s = 6'(m_s);
                e.m = 6'(m_m);
                e.h = 5'(m_h);
                e.p = p;
            end
            sbq.push_back(e);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk("sec", 32'(bus.sec), 32'(e.s));
            chk("min", 32'(bus.min), 32'(e.m));
            chk("hour", 32'(bus.hour), 32'(e.h));
            chk("pulses", 32'({bus.day_pulse, bus.min_pulse, bus.sec_pulse}),
                32'(e.p));
            cyc_no++;
            if (bus.sec_pulse) sp_q.push_back(cyc_no);
            if (bus.sec_pulse || bus.min_pulse || bus.day_pulse) np_all++;
        end
    endtask

    task automatic pulse_dec();
        bus.decrement = 1'b1;
        cyc(1);
        bus.decrement = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_inc();
        bus.increment = 1'b1;
        cyc(1);
        bus.increment = 1'b0;
        cyc(1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.run = 1'b0;
        bus.select = 2'b00;
        bus.increment = 1'b0;
        bus.decrement = 1'b0;
        cyc(2);
        chk("rst_time", 32'({bus.hour, bus.min, bus.sec}), 32'd0);
        reset = 1'b0;

        // Free run: two seconds in eight clocks
        bus.run = 1'b1;
        sp_q.delete();
        cyc(8);
        chk("run8_sec", 32'(bus.sec), 32'd2);
        chk("run8_npulse", 32'(sp_q.size()), 32'd2);
        if (sp_q.size() == 2)
            chk("run8_gap", 32'(sp_q[1] - sp_q[0]), 32'd4);

        // 00:00:59 then a tick carries into minutes
        bus.run = 1'b0;
        bus.select = 2'b01;
        repeat (3) pulse_dec();
        chk("pre59_sec", 32'(bus.sec), 32'd59);
        bus.select = 2'b00;
        bus.run = 1'b1;
        cyc(4);
        chk("carry_time", 32'({bus.hour, bus.min, bus.sec}),
            32'({5'd0, 6'd1, 6'd0}));
        chk("carry_pulses",
            32'({bus.day_pulse, bus.min_pulse, bus.sec_pulse}), 32'd3);
        cyc(1);

        // 23:59:59 then a tick wraps the day
        bus.run = 1'b0;
        bus.select = 2'b01;
        pulse_dec();
        bus.select = 2'b10;
        repeat (2) pulse_dec();
        bus.select = 2'b11;
        pulse_dec();
        chk("pre_day", 32'({bus.hour, bus.min, bus.sec}),
            32'({5'd23, 6'd59, 6'd59}));
        bus.select = 2'b00;
        bus.run = 1'b1;
        cyc(4);
        chk("day_time", 32'({bus.hour, bus.min, bus.sec}), 32'd0);
        chk("day_pulses",
            32'({bus.day_pulse, bus.min_pulse, bus.sec_pulse}), 32'd7);

        // Manual hour wrap, held increment counts once
        bus.run = 1'b0;
        bus.select = 2'b11;
        pulse_dec();
        chk("hour23", 32'(bus.hour), 32'd23);
        np_all = 0;
        bus.increment = 1'b1;
        cyc(1);
        chk("hwrap_time", 32'({bus.hour, bus.min, bus.sec}), 32'd0);
        cyc(9);
        chk("hold_hour", 32'(bus.hour), 32'd0);
        chk("hwrap_nopulse", 32'(np_all), 32'd0);
        bus.increment = 1'b0;
        cyc(1);

        // Adjust on the terminal prescaler count suppresses the tick
        bus.select = 2'b00;
        bus.run = 1'b1;
        cyc(3);
        bus.select = 2'b10;
        bus.increment = 1'b1;
        sp_q.delete();
        cyc(1);
        chk("adj_min", 32'(bus.min), 32'd1);
        chk("adj_sec", 32'(bus.sec), 32'd0);
        chk("adj_nosp", 32'(bus.sec_pulse), 32'd0);
        bus.increment = 1'b0;
        bus.select = 2'b00;
        cyc(3);
        chk("adj_wait", 32'(sp_q.size()), 32'd0);
        cyc(1);
        chk("adj_next_sp", 32'(bus.sec_pulse), 32'd1);
        chk("adj_next_sec", 32'(bus.sec), 32'd1);

        // Cancelling edges, then frozen time
        bus.run = 1'b0;
        bus.select = 2'b01;
        repeat (4) pulse_inc();
        chk("sec5", 32'(bus.sec), 32'd5);
        bus.increment = 1'b1;
        bus.decrement = 1'b1;
        cyc(1);
        chk("cancel_sec", 32'(bus.sec), 32'd5);
        bus.increment = 1'b0;
        bus.decrement = 1'b0;
        bus.select = 2'b00;
        cyc(1);
        np_all = 0;
        cyc(20);
        chk("frozen_time", 32'({bus.hour, bus.min, bus.sec}),
            32'({5'd0, 6'd1, 6'd5}));
        chk("frozen_nopulse", 32'(np_all), 32'd0);

        // Reset mid-count with increment held through release
        bus.run = 1'b1;
        cyc(2);
        bus.select = 2'b01;
        bus.increment = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rst", 32'({bus.hour, bus.min, bus.sec}), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rel_edge_sec", 32'(bus.sec), 32'd1);
        bus.increment = 1'b0;
        sp_q.delete();
        cyc(3);
        chk("rel_wait", 32'(sp_q.size()), 32'd0);
        cyc(1);
        chk("rel_tick_sec", 32'(bus.sec), 32'd2);
        chk("rel_tick_sp", 32'(bus.sec_pulse), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, giving clk cycles per second (legal range 2 to 2^32-1).
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port run  input  1  enables timekeeping; 0 freezes the prescaler and time.
REQ-005 The block SHALL have port select  input  2  field to adjust: 00 none, 01 sec, 10 min, 11 hour.
REQ-006 The block SHALL have port increment  input  1  level input; each rising edge raises the selected field by 1.
REQ-007 The block SHALL have port decrement  input  1  level input; each rising edge lowers the selected field by 1.
REQ-008 The block SHALL have port sec  output  6  current seconds, 0..59.
REQ-009 The block SHALL have port min  output  6  current minutes, 0..59.
REQ-010 The block SHALL have port hour  output  5  current hours, 0..23.
REQ-011 The block SHALL have port sec_pulse  output  1  one-cycle strobe on each tick-driven second advance.
REQ-012 The block SHALL have port min_pulse  output  1  one-cycle strobe when a tick carries into minutes.
REQ-013 The block SHALL have port day_pulse  output  1  one-cycle strobe when a tick wraps 23:59:59 to 00:00:00.

Function
REQ-014 The block SHALL hold a prescaler that counts 0..TICKS_PER_SEC-1 while run=1 and holds its value while run=0.
REQ-015 When run=1 and the prescaler equals TICKS_PER_SEC-1, the prescaler SHALL go to 0 and a tick advance SHALL occur in that same edge.
REQ-016 A tick advance SHALL increment sec; at 59 it SHALL wrap to 0 and carry to min; at min 59 it SHALL wrap to 0 and carry to hour; at hour 23 it SHALL wrap to 0.
REQ-017 sec_pulse SHALL be registered high for exactly the cycle in which the advanced time first appears on the outputs; min_pulse and day_pulse likewise when their carry/wrap occurs.
REQ-018 increment and decrement SHALL each be edge-detected against a registered previous value; an edge is inc=1 and prev=0.
REQ-019 A single increment edge with select != 00 SHALL add 1 to the selected field, wrapping 59->0 (sec, min) or 23->0 (hour), with no carry to other fields.
REQ-020 A single decrement edge with select != 00 SHALL subtract 1 from the selected field, wrapping 0->59 (sec, min) or 0->23 (hour), with no borrow.
REQ-021 Rising edges of increment and decrement in the same cycle SHALL cancel: no field change, no prescaler effect.
REQ-022 With select=00, edges SHALL be ignored and SHALL not affect the prescaler.
REQ-023 An applied adjustment SHALL clear the prescaler to 0 and SHALL suppress any tick advance in that cycle; no pulse is generated.
REQ-024 Adjustments SHALL be accepted regardless of run.
REQ-025 Manual wraps SHALL never assert sec_pulse, min_pulse or day_pulse.
REQ-026 Outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-027 While reset=1, sec, min, hour, prescaler, all pulses and both previous-edge registers SHALL be 0.
REQ-028 Reset asserted mid-count SHALL abort the current second; counting restarts from prescaler 0 after release.
REQ-029 An increment or decrement held high through reset release SHALL count as a rising edge on the first clock after release.

Verification (TICKS_PER_SEC=4)
REQ-030 Reset, run=1, 8 clocks -> sec=2, sec_pulse high exactly 2 single cycles, 4 clocks apart.
REQ-031 Preload 00:00:59 via decrement (select=01), run 4 clocks -> 00:01:00, sec_pulse and min_pulse high same cycle, day_pulse low.
REQ-032 Preload 23:59:59 (decrements on each field), run 4 clocks -> 00:00:00, sec_pulse, min_pulse, day_pulse all high one cycle.
REQ-033 select=11, hour=23, one increment edge -> hour=0, min/sec unchanged, no pulses; increment held high 10 clocks -> only one change.
REQ-034 run=1, increment edge (select=10) on the cycle prescaler=3 -> min+1, sec unchanged, no sec_pulse, next sec_pulse 4 clocks later.
REQ-035 Increment and decrement rising same cycle (select=01, sec=5) -> sec stays 5; run=0 for 20 clocks -> time unchanged, no pulses.
